// File: rtl/speed_controller_if.sv
// Frame tick, raw push-buttons and speed outputs shared between the board-side
// driver (master) and the speed controller (slave).
interface speed_controller_if;
  logic       next_frame;
  logic       btn_faster;
  logic       btn_slower;
  logic       btn_pause;
  logic [2:0] step_size;
  logic [2:0] target;
  logic       paused;

  modport master (
    output next_frame, btn_faster, btn_slower, btn_pause,
    input  step_size, target, paused
  );

  modport slave (
    input  next_frame, btn_faster, btn_slower, btn_pause,
    output step_size, target, paused
  );
endinterface

// File: rtl/speed_controller.sv
// Push-button speed control: synchronise, debounce per frame, auto-repeat on held
// faster/slower, saturating target, pause toggle and a 1-LSB ramp of step_size.
module speed_controller #(
  parameter int unsigned DEBOUNCE_FRAMES = 4,
  parameter int unsigned REPEAT_DELAY    = 30,
  parameter int unsigned REPEAT_RATE     = 8,
  parameter int unsigned RAMP_FRAMES     = 2,
  parameter logic [2:0]  RESET_STEP      = 3'd2
) (
  input  logic               clk,
  input  logic               rst,
  speed_controller_if.slave  bus
);

  localparam int BTN_FASTER = 0;
  localparam int BTN_SLOWER = 1;
  localparam int BTN_PAUSE  = 2;

  localparam logic [3:0] DEB_LIMIT  = 4'(DEBOUNCE_FRAMES);
  localparam logic [5:0] DELAY_LOAD = 6'(REPEAT_DELAY);
  localparam logic [5:0] RATE_LOAD  = 6'(REPEAT_RATE);
  localparam logic [3:0] RAMP_LAST  = 4'(RAMP_FRAMES - 1);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_HOLD,
    RPT_REPEAT
  } rpt_state_t;

  logic [2:0] btn_raw;
  logic [2:0] sync1_reg;
  logic [2:0] sync2_reg;
  logic [2:0] db_level;
  logic [2:0] db_next;
  logic [2:0] press;
  logic [1:0] rpt_event;

  assign btn_raw = {bus.btn_pause, bus.btn_slower, bus.btn_faster};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // A level is accepted on the frame its stability count would reach the limit,
  // so press, event and target update all land on that same frame.
  for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
    logic       db_reg;
    logic [3:0] stab_cnt_reg;
    logic [3:0] stab_cnt_inc;
    logic       differs;
    logic       accept;

    assign stab_cnt_inc = stab_cnt_reg + 4'd1;
    assign differs      = (sync2_reg[gi] != db_reg);
    assign accept       = differs && (stab_cnt_inc == DEB_LIMIT);
    assign db_next[gi]  = accept ? sync2_reg[gi] : db_reg;
    assign db_level[gi] = db_reg;
    assign press[gi]    = bus.next_frame & accept & sync2_reg[gi];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_reg       <= 1'b0;
        stab_cnt_reg <= '0;
      end else if (bus.next_frame) begin
        db_reg <= db_next[gi];
        if (!differs || accept) begin
          stab_cnt_reg <= '0;
        end else begin
          stab_cnt_reg <= stab_cnt_inc;
        end
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_repeat
    rpt_state_t state_reg;
    logic [5:0] frame_cnt_reg;
    logic       expire;

    assign expire = (frame_cnt_reg == 6'd1);

    // Events are decoded from state so they coincide with the press frame.
    assign rpt_event[gi] = bus.next_frame & db_next[gi] &
                           (((state_reg == RPT_IDLE) & press[gi]) |
                            ((state_reg != RPT_IDLE) & expire));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_reg     <= RPT_IDLE;
        frame_cnt_reg <= '0;
      end else if (bus.next_frame) begin
        if (!db_next[gi]) begin
          state_reg     <= RPT_IDLE;
          frame_cnt_reg <= '0;
        end else begin
          case (state_reg)
            RPT_IDLE: begin
              if (press[gi]) begin
                state_reg     <= RPT_HOLD;
                frame_cnt_reg <= DELAY_LOAD;
              end
            end
            RPT_HOLD: begin
              if (expire) begin
                state_reg     <= RPT_REPEAT;
                frame_cnt_reg <= RATE_LOAD;
              end else begin
                frame_cnt_reg <= frame_cnt_reg - 6'd1;
              end
            end
            RPT_REPEAT: begin
              if (expire) begin
                frame_cnt_reg <= RATE_LOAD;
              end else begin
                frame_cnt_reg <= frame_cnt_reg - 6'd1;
              end
            end
            default: begin
              state_reg     <= RPT_IDLE;
              frame_cnt_reg <= '0;
            end
          endcase
        end
      end
    end
  end

  logic [2:0] target_reg;
  logic [2:0] target_next;
  logic       paused_reg;
  logic [2:0] step_reg;
  logic [3:0] ramp_cnt_reg;
  logic [2:0] eff_target;

  assign eff_target = paused_reg ? 3'd0 : target_reg;

  // Opposing events in one frame cancel; saturation at either end is silent.
  always_comb begin
    target_next = target_reg;
    if (rpt_event[BTN_FASTER] && !rpt_event[BTN_SLOWER] && target_reg != 3'd7) begin
      target_next = target_reg + 3'd1;
    end else if (rpt_event[BTN_SLOWER] && !rpt_event[BTN_FASTER] && target_reg != 3'd0) begin
      target_next = target_reg - 3'd1;
    end
  end

  // Ramp counter parks at 0 while settled, so a new target moves on the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_reg   <= RESET_STEP;
      paused_reg   <= 1'b0;
      step_reg     <= RESET_STEP;
      ramp_cnt_reg <= '0;
    end else if (bus.next_frame) begin
      target_reg <= target_next;
      if (press[BTN_PAUSE]) begin
        paused_reg <= ~paused_reg;
      end
      if (step_reg == eff_target) begin
        ramp_cnt_reg <= '0;
      end else begin
        if (ramp_cnt_reg == 4'd0) begin
          step_reg <= (step_reg < eff_target) ? step_reg + 3'd1 : step_reg - 3'd1;
        end
        ramp_cnt_reg <= (ramp_cnt_reg == RAMP_LAST) ? 4'd0 : ramp_cnt_reg + 4'd1;
      end
    end
  end

  assign bus.step_size = step_reg;
  assign bus.target    = target_reg;
  assign bus.paused    = paused_reg;

endmodule

// File: tb/tb_speed_controller.sv
// Scoreboarded bench: tests queue the frame and value of each expected target/paused
// change; a per-frame monitor pops and compares, and checks every step_size move.
module tb_speed_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  speed_controller_if bus ();

  speed_controller #(
    .DEBOUNCE_FRAMES(4),
    .REPEAT_DELAY   (30),
    .REPEAT_RATE    (8),
    .RAMP_FRAMES    (2),
    .RESET_STEP     (3'd2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int         frame;
    logic [2:0] val;
  } exp_t;

  exp_t tgt_q[$];
  exp_t pau_q[$];

  int checks = 0;
  int passes = 0;
  int frame_no = 0;

  logic [2:0] prev_target;
  logic [2:0] prev_step;
  logic       prev_paused;

  task automatic observe();
    exp_t e;
    logic [2:0] eff;
    logic [2:0] step_exp;
    if (bus.target !== prev_target) begin
      checks++;
      if (tgt_q.size() == 0) begin
        $display("FAIL target_unexpected: got %0d at frame %0d, required no change from %0d",
                 bus.target, frame_no, prev_target);
      end else begin
        e = tgt_q.pop_front();
        if (bus.target !== e.val || frame_no != e.frame)
          $display("FAIL target_event: got %0d at frame %0d, required %0d at frame %0d",
                   bus.target, frame_no, e.val, e.frame);
        else begin
          passes++;
          $display("target -> %0d at frame %0d", bus.target, frame_no);
        end
      end
    end
    if (bus.paused !== prev_paused) begin
      checks++;
      if (pau_q.size() == 0) begin
        $display("FAIL paused_unexpected: got %0b at frame %0d, required no change",
                 bus.paused, frame_no);
      end else begin
        e = pau_q.pop_front();
        if (bus.paused !== e.val[0] || frame_no != e.frame)
          $display("FAIL paused_event: got %0b at frame %0d, required %0b at frame %0d",
                   bus.paused, frame_no, e.val[0], e.frame);
        else begin
          passes++;
          $display("paused -> %0b at frame %0d", bus.paused, frame_no);
        end
      end
    end
    if (bus.step_size !== prev_step) begin
      checks++;
      eff = prev_paused ? 3'd0 : prev_target;
      if (eff > prev_step)      step_exp = prev_step + 3'd1;
      else if (eff < prev_step) step_exp = prev_step - 3'd1;
      else                      step_exp = prev_step;
      if (bus.step_size !== step_exp)
        $display("FAIL step_move: got %0d at frame %0d, required %0d (from %0d toward %0d)",
                 bus.step_size, frame_no, step_exp, prev_step, eff);
      else begin
        passes++;
        $display("step_size -> %0d at frame %0d", bus.step_size, frame_no);
      end
    end
    prev_target = bus.target;
    prev_step   = bus.step_size;
    prev_paused = bus.paused;
  endtask

  task automatic tick();
    @(negedge clk);
    bus.next_frame = 1'b1;
    @(negedge clk);
    bus.next_frame = 1'b0;
    frame_no++;
    observe();
    @(negedge clk);
  endtask

  task automatic set_buttons(input logic f, input logic s, input logic p);
    @(negedge clk);
    bus.btn_faster = f;
    bus.btn_slower = s;
    bus.btn_pause  = p;
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_target(input int f, input logic [2:0] v);
    tgt_q.push_back('{frame: f, val: v});
  endtask

  task automatic expect_paused(input int f, input logic v);
    pau_q.push_back('{frame: f, val: {2'b00, v}});
  endtask

  task automatic test_reset();
    bus.next_frame = 1'b0;
    bus.btn_faster = 1'b0;
    bus.btn_slower = 1'b0;
    bus.btn_pause  = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (bus.step_size !== 3'd2) $display("FAIL reset_step: got %0d, required 2", bus.step_size);
    else passes++;
    checks++;
    if (bus.target !== 3'd2) $display("FAIL reset_target: got %0d, required 2", bus.target);
    else passes++;
    checks++;
    if (bus.paused !== 1'b0) $display("FAIL reset_paused: got %0b, required 0", bus.paused);
    else passes++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    prev_target = 3'd2;
    prev_step   = 3'd2;
    prev_paused = 1'b0;
    repeat (10) tick();
    checks++;
    if (bus.step_size !== 3'd2 || bus.target !== 3'd2 || bus.paused !== 1'b0)
      $display("FAIL idle_hold: got step %0d target %0d paused %0b, required 2 2 0",
               bus.step_size, bus.target, bus.paused);
    else passes++;
    $display("reset test done at frame %0d", frame_no);
  endtask

  task automatic test_single_press();
    int f0;
    f0 = frame_no;
    expect_target(f0 + 4, 3'd3);
    set_buttons(1'b1, 1'b0, 1'b0);
    repeat (6) tick();
    checks++;
    if (bus.step_size !== 3'd3)
      $display("FAIL press_step: got %0d two frames after target change, required 3", bus.step_size);
    else passes++;
    repeat (4) tick();
    set_buttons(1'b0, 1'b0, 1'b0);
    repeat (10) tick();
    checks++;
    if (bus.target !== 3'd3 || tgt_q.size() != 0)
      $display("FAIL press_target: got %0d with %0d events outstanding, required 3 with 0",
               bus.target, tgt_q.size());
    else passes++;
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) begin
      set_buttons(1'b0, (i % 2) == 0, 1'b0);
      tick();
    end
    set_buttons(1'b0, 1'b0, 1'b0);
    repeat (6) tick();
    checks++;
    if (bus.target !== 3'd3)
      $display("FAIL bounce_target: got %0d, required 3", bus.target);
    else passes++;
  endtask

  task automatic test_reset_midrun();
    int f0;
    f0 = frame_no;
    expect_target(f0 + 4, 3'd4);
    set_buttons(1'b1, 1'b0, 1'b0);
    repeat (10) tick();
    checks++;
    if (bus.target !== 3'd4 || tgt_q.size() != 0)
      $display("FAIL midrun_press: got %0d with %0d outstanding, required 4 with 0",
               bus.target, tgt_q.size());
    else passes++;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (bus.step_size !== 3'd2 || bus.target !== 3'd2 || bus.paused !== 1'b0)
      $display("FAIL midrun_reset: got step %0d target %0d paused %0b, required 2 2 0",
               bus.step_size, bus.target, bus.paused);
    else passes++;
    @(negedge clk);
    bus.btn_faster = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    prev_target = 3'd2;
    prev_step   = 3'd2;
    prev_paused = 1'b0;
    repeat (40) tick();
    checks++;
    if (bus.target !== 3'd2 || bus.step_size !== 3'd2)
      $display("FAIL midrun_residual: got target %0d step %0d, required 2 2",
               bus.target, bus.step_size);
    else passes++;
  endtask

  task automatic test_auto_repeat();
    int f0;
    f0 = frame_no;
    expect_target(f0 + 4,  3'd3);
    expect_target(f0 + 34, 3'd4);
    expect_target(f0 + 42, 3'd5);
    expect_target(f0 + 50, 3'd6);
    expect_target(f0 + 58, 3'd7);
    set_buttons(1'b1, 1'b0, 1'b0);
    repeat (120) tick();
    set_buttons(1'b0, 1'b0, 1'b0);
    repeat (8) tick();
    checks++;
    if (bus.target !== 3'd7 || bus.step_size !== 3'd7 || tgt_q.size() != 0)
      $display("FAIL repeat_final: got target %0d step %0d outstanding %0d, required 7 7 0",
               bus.target, bus.step_size, tgt_q.size());
    else passes++;
  endtask

  task automatic test_pause();
    int f0;
    for (int k = 0; k < 3; k++) begin
      f0 = frame_no;
      expect_target(f0 + 4, 3'(6 - k));
      set_buttons(1'b0, 1'b1, 1'b0);
      repeat (5) tick();
      set_buttons(1'b0, 1'b0, 1'b0);
      repeat (5) tick();
    end
    repeat (10) tick();
    checks++;
    if (bus.step_size !== 3'd4 || bus.target !== 3'd4)
      $display("FAIL pause_setup: got step %0d target %0d, required 4 4", bus.step_size, bus.target);
    else passes++;

    f0 = frame_no;
    expect_paused(f0 + 4, 1'b1);
    set_buttons(1'b0, 1'b0, 1'b1);
    repeat (12) tick();
    checks++;
    if (bus.step_size !== 3'd0 || bus.paused !== 1'b1)
      $display("FAIL pause_ramp_down: got step %0d paused %0b, required 0 1", bus.step_size, bus.paused);
    else passes++;
    set_buttons(1'b0, 1'b0, 1'b0);
    repeat (6) tick();

    f0 = frame_no;
    expect_target(f0 + 4, 3'd5);
    set_buttons(1'b1, 1'b0, 1'b0);
    repeat (5) tick();
    set_buttons(1'b0, 1'b0, 1'b0);
    repeat (6) tick();
    checks++;
    if (bus.step_size !== 3'd0 || bus.target !== 3'd5 || bus.paused !== 1'b1)
      $display("FAIL paused_faster: got step %0d target %0d paused %0b, required 0 5 1",
               bus.step_size, bus.target, bus.paused);
    else passes++;

    f0 = frame_no;
    expect_paused(f0 + 4, 1'b0);
    set_buttons(1'b0, 1'b0, 1'b1);
    repeat (5) tick();
    set_buttons(1'b0, 1'b0, 1'b0);
    repeat (12) tick();
    checks++;
    if (bus.step_size !== 3'd5 || bus.paused !== 1'b0 || tgt_q.size() != 0 || pau_q.size() != 0)
      $display("FAIL unpause_ramp: got step %0d paused %0b outstanding %0d/%0d, required 5 0 0/0",
               bus.step_size, bus.paused, tgt_q.size(), pau_q.size());
    else passes++;
  endtask

  task automatic test_simultaneous();
    int f0;
    f0 = frame_no;
    set_buttons(1'b1, 1'b1, 1'b0);
    repeat (10) tick();
    checks++;
    if (bus.target !== 3'd5)
      $display("FAIL simul_cancel: got %0d, required 5", bus.target);
    else passes++;
    expect_target(f0 + 34, 3'd6);
    set_buttons(1'b1, 1'b0, 1'b0);
    repeat (25) tick();
    set_buttons(1'b0, 1'b0, 1'b0);
    repeat (15) tick();
    checks++;
    if (bus.target !== 3'd6 || bus.step_size !== 3'd6 || tgt_q.size() != 0)
      $display("FAIL simul_repeat: got target %0d step %0d outstanding %0d, required 6 6 0",
               bus.target, bus.step_size, tgt_q.size());
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_reset_midrun();
    test_auto_repeat();
    test_pause();
    test_simultaneous();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
